// File: rtl/ltssm_polling_ctrl.sv
// LTSSM Polling sequencer: drives TS1 (Polling.Active) then TS2 (Polling.Configuration),
// counts sent/received training sets per lane and reports done or timeout.

module ltssm_polling_lane #(
  parameter int RX_MATCH = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic cfg_i,
  input  logic rx_valid_i,
  input  logic rx_ts1_i,
  input  logic rx_ts2_i,
  output logic matched_o
);
  localparam int RX_W = $clog2(RX_MATCH + 1);

  logic [RX_W-1:0] cnt_q;
  logic            good;

  // Polling.Active accepts either TS type; Polling.Configuration needs TS2
  assign good = cfg_i ? rx_ts2_i : (rx_ts1_i | rx_ts2_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && rx_valid_i) begin
      if (!good)                          cnt_q <= '0;
      else if (cnt_q != RX_W'(RX_MATCH))  cnt_q <= cnt_q + 1'b1;
    end
  end

  assign matched_o = (cnt_q == RX_W'(RX_MATCH));
endmodule

module ltssm_polling_ctrl #(
  parameter int NUM_LANES      = 1,
  parameter int TS1_MIN_TX     = 1024,
  parameter int RX_MATCH       = 8,
  parameter int TS2_MIN_TX     = 16,
  parameter int TIMEOUT_CYCLES = 24000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [NUM_LANES-1:0] lanes_detected_i,
  input  logic                 tx_os_ready_i,
  input  logic [NUM_LANES-1:0] rx_os_valid_i,
  input  logic [NUM_LANES-1:0] rx_ts1_i,
  input  logic [NUM_LANES-1:0] rx_ts2_i,
  output logic                 tx_os_req_o,
  output logic [1:0]           tx_os_type_o,
  output logic [NUM_LANES-1:0] tx_lanes_o,
  output logic [1:0]           state_o,
  output logic                 done_o,
  output logic                 timeout_o
);
  localparam int TS_MAX = (TS1_MIN_TX > TS2_MIN_TX) ? TS1_MIN_TX : TS2_MIN_TX;
  localparam int TS_W   = $clog2(TS_MAX + 1);
  localparam int TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Encoding doubles as the tx_os_type_o code (none / TS1 / TS2)
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_CONFIG = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_LANES-1:0] lanes_q, lanes_d, matched, lane_hit;
  logic [TS_W-1:0]      ts_cnt_q, ts_cnt_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 seen_q, seen_d;
  logic                 req_q, done_q, tmo_q;
  logic                 done_d, tmo_d, clr_cnt;
  logic                 accept, all_match, any_match, tmr_exp, ts2_rx, ts_sat;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ltssm_polling_lane #(.RX_MATCH(RX_MATCH)) u_lane (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (clr_cnt),
      .en_i       (lanes_q[i]),
      .cfg_i      (state_q == ST_CONFIG),
      .rx_valid_i (rx_os_valid_i[i]),
      .rx_ts1_i   (rx_ts1_i[i]),
      .rx_ts2_i   (rx_ts2_i[i]),
      .matched_o  (matched[i])
    );
  end

  assign lane_hit  = matched & lanes_q;
  assign accept    = req_q & tx_os_ready_i;
  assign all_match = (lane_hit == lanes_q);
  assign any_match = |lane_hit;
  assign tmr_exp   = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign ts2_rx    = |(rx_os_valid_i & rx_ts2_i & lanes_q);
  assign ts_sat    = (ts_cnt_q == TS_W'(TS_MAX));

  always_comb begin
    state_d  = state_q;
    lanes_d  = lanes_q;
    ts_cnt_d = ts_cnt_q;
    tmr_d    = tmr_q;
    seen_d   = seen_q;
    done_d   = 1'b0;
    tmo_d    = 1'b0;
    clr_cnt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (|lanes_detected_i) begin
            lanes_d = lanes_detected_i;
            state_d = ST_ACTIVE;
          end else begin
            lanes_d = '0;
            tmo_d   = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        tmr_d = tmr_q + 1'b1;
        if (accept && !ts_sat) ts_cnt_d = ts_cnt_q + 1'b1;
        if (ts_cnt_q >= TS_W'(TS1_MIN_TX) && all_match) begin
          state_d = ST_CONFIG;
        end else if (tmr_exp) begin
          // Degrade to the lanes that trained rather than give up on the link
          if (ts_cnt_q >= TS_W'(TS1_MIN_TX) && any_match) begin
            state_d = ST_CONFIG;
            lanes_d = lane_hit;
          end else begin
            state_d = ST_IDLE;
            lanes_d = '0;
            tmo_d   = 1'b1;
          end
        end
      end
      ST_CONFIG: begin
        tmr_d  = tmr_q + 1'b1;
        seen_d = seen_q | ts2_rx;
        if (accept && (seen_q || ts2_rx) && !ts_sat) ts_cnt_d = ts_cnt_q + 1'b1;
        if (all_match && ts_cnt_q >= TS_W'(TS2_MIN_TX)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (tmr_exp) begin
          state_d = ST_IDLE;
          lanes_d = '0;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Every phase starts from clean counters; IDLE holds them at zero
    clr_cnt = (state_d != state_q) || (state_q == ST_IDLE);
    if (clr_cnt) begin
      ts_cnt_d = '0;
      tmr_d    = '0;
      seen_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      lanes_q  <= '0;
      ts_cnt_q <= '0;
      tmr_q    <= '0;
      seen_q   <= 1'b0;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lanes_q  <= lanes_d;
      ts_cnt_q <= ts_cnt_d;
      tmr_q    <= tmr_d;
      seen_q   <= seen_d;
      req_q    <= (state_d != ST_IDLE);
      done_q   <= done_d;
      tmo_q    <= tmo_d;
    end
  end

  assign tx_os_req_o  = req_q;
  assign tx_os_type_o = state_q;
  assign state_o      = state_q;
  assign tx_lanes_o   = lanes_q;
  assign done_o       = done_q;
  assign timeout_o    = tmo_q;
endmodule

// File: tb/tb_ltssm_polling_ctrl.sv
// Bench for ltssm_polling_ctrl: directed table, multi-cycle corner sequences and
// randomized traffic compared against a cycle-level behavioural model.

module tb_ltssm_polling_ctrl;
  localparam int NL    = 4;
  localparam int TS1   = 16;
  localparam int RXM   = 8;
  localparam int TS2   = 16;
  localparam int TMO   = 1000;
  localparam int TSMAX = (TS1 > TS2) ? TS1 : TS2;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b0;
  logic [NL-1:0] det = '0, rxv = '0, rx1 = '0, rx2 = '0;
  logic          req, done, tmo;
  logic [1:0]    typ, st;
  logic [NL-1:0] lanes;

  ltssm_polling_ctrl #(
    .NUM_LANES(NL), .TS1_MIN_TX(TS1), .RX_MATCH(RXM), .TS2_MIN_TX(TS2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .lanes_detected_i(det),
    .tx_os_ready_i(ready), .rx_os_valid_i(rxv), .rx_ts1_i(rx1), .rx_ts2_i(rx2),
    .tx_os_req_o(req), .tx_os_type_o(typ), .tx_lanes_o(lanes), .state_o(st),
    .done_o(done), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  bit chk_en = 1'b0;

  // Behavioural model: integer counters advanced once per clock from the Polling rules
  int            m_state = 0, m_ts = 0, m_tmr = 0;
  int            m_rx[NL] = '{default: 0};
  bit            m_seen = 1'b0, m_done = 1'b0, m_tmo = 1'b0;
  logic [NL-1:0] m_mask = '0;

  task automatic m_reset();
    m_state = 0; m_ts = 0; m_tmr = 0; m_seen = 1'b0; m_done = 1'b0; m_tmo = 1'b0; m_mask = '0;
    for (int i = 0; i < NL; i++) m_rx[i] = 0;
  endtask

  task automatic m_step();
    logic [NL-1:0] mm;
    bit acc, ts2_now;
    int nxt, ts_pre, tmr_pre;
    acc = (m_state != 0) && ready;
    m_done = 1'b0; m_tmo = 1'b0;
    if (m_state == 0) begin
      if (start) begin
        if (det != 0) begin m_mask = det; m_state = 1; end
        else begin m_tmo = 1'b1; m_mask = '0; end
      end
      return;
    end
    mm = '0;
    for (int i = 0; i < NL; i++) if (m_mask[i] && m_rx[i] == RXM) mm[i] = 1'b1;
    ts_pre = m_ts; tmr_pre = m_tmr; nxt = m_state;
    ts2_now = |(rxv & rx2 & m_mask);
    for (int i = 0; i < NL; i++) begin
      if (m_mask[i] && rxv[i]) begin
        if (rx2[i] || (m_state == 1 && rx1[i])) m_rx[i] = (m_rx[i] < RXM) ? m_rx[i] + 1 : RXM;
        else m_rx[i] = 0;
      end
    end
    if (acc && (m_state == 1 || m_seen || ts2_now) && m_ts < TSMAX) m_ts++;
    if (m_state == 2 && ts2_now) m_seen = 1'b1;
    m_tmr++;
    if (m_state == 1) begin
      if (ts_pre >= TS1 && mm == m_mask) nxt = 2;
      else if (tmr_pre == TMO - 1) begin
        if (ts_pre >= TS1 && mm != 0) begin nxt = 2; m_mask = mm; end
        else begin nxt = 0; m_tmo = 1'b1; m_mask = '0; end
      end
    end else begin
      if (mm == m_mask && ts_pre >= TS2) begin nxt = 0; m_done = 1'b1; end
      else if (tmr_pre == TMO - 1) begin nxt = 0; m_tmo = 1'b1; m_mask = '0; end
    end
    if (nxt != m_state) begin
      m_ts = 0; m_tmr = 0; m_seen = 1'b0;
      for (int i = 0; i < NL; i++) m_rx[i] = 0;
      m_state = nxt;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) m_reset();
    else m_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      n_vec++;
      if (st !== 2'(m_state) || req !== (m_state != 0) || typ !== 2'(m_state) ||
          lanes !== m_mask || done !== m_done || tmo !== m_tmo) begin
        n_err++;
        $display("FAIL model t=%0t got st=%0d req=%0b typ=%0d lanes=%b done=%0b tmo=%0b exp st=%0d req=%0b lanes=%b done=%0b tmo=%0b",
                 $time, st, req, typ, lanes, done, tmo, m_state, (m_state != 0), m_mask, m_done, m_tmo);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [1:0] es, input logic [NL-1:0] el,
                     input logic ed, input logic et);
    logic [NL+6:0] g, e;
    g = {st, req, typ, lanes, done, tmo};
    e = {es, (es != 2'd0), es, el, ed, et};
    n_vec++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s got st=%0d req=%0b typ=%0d lanes=%b done=%0b tmo=%0b exp st=%0d lanes=%b done=%0b tmo=%0b",
               nm, st, req, typ, lanes, done, tmo, es, el, ed, et);
    end
  endtask

  task automatic clr_in();
    start = 1'b0; det = '0; rxv = '0; rx1 = '0; rx2 = '0;
  endtask

  task automatic do_reset();
    clr_in(); rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
  endtask

  typedef struct {
    string         nm;
    logic          s;
    logic [NL-1:0] d, rv, r1;
    logic [1:0]    es;
    logic [NL-1:0] el;
    logic          ed, et;
  } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{"idle",          1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 4'h0, 1'b0, 1'b0};
    tbl[1] = '{"zero_start",    1'b1, 4'h0, 4'h0, 4'h0, 2'd0, 4'h0, 1'b0, 1'b1};
    tbl[2] = '{"after_zero",    1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 4'h0, 1'b0, 1'b0};
    tbl[3] = '{"start",         1'b1, 4'h5, 4'h0, 4'h0, 2'd1, 4'h5, 1'b0, 1'b0};
    tbl[4] = '{"start_ignored", 1'b1, 4'hF, 4'h0, 4'h0, 2'd1, 4'h5, 1'b0, 1'b0};
    tbl[5] = '{"active_rx",     1'b0, 4'h0, 4'h1, 4'h1, 2'd1, 4'h5, 1'b0, 1'b0};

    cyc(2);
    chk("reset", 2'd0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0; cyc(1);
    chk_en = 1'b1;

    // Table: IDLE/start edge behaviour
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start = tbl[i].s; det = tbl[i].d; rxv = tbl[i].rv; rx1 = tbl[i].r1; rx2 = '0;
      cyc();
      chk(tbl[i].nm, tbl[i].es, tbl[i].el, tbl[i].ed, tbl[i].et);
    end

    // Happy path on all four lanes
    do_reset();
    det = 4'hF; start = 1'b1; ready = 1'b1; cyc(); start = 1'b0; det = '0;
    chk("hp_enter", 2'd1, 4'hF, 1'b0, 1'b0);
    for (int j = 0; j < 16; j++) begin
      rxv = (j < 8) ? 4'hF : 4'h0; rx1 = rxv; cyc();
    end
    chk("hp_active_hold", 2'd1, 4'hF, 1'b0, 1'b0);
    cyc(); chk("hp_config", 2'd2, 4'hF, 1'b0, 1'b0);
    for (int j = 0; j < 16; j++) begin
      rxv = (j < 8) ? 4'hF : 4'h0; rx2 = rxv; rx1 = '0; cyc();
    end
    chk("hp_cfg_hold", 2'd2, 4'hF, 1'b0, 1'b0);
    clr_in(); cyc(); chk("hp_done", 2'd0, 4'hF, 1'b1, 1'b0);
    cyc(); chk("hp_lanes_kept", 2'd0, 4'hF, 1'b0, 1'b0);

    // Partial-lane timeout: only lanes 0/1 train, lanes 2/3 never get 8 in a row
    do_reset();
    det = 4'hF; start = 1'b1; ready = 1'b1; cyc(); start = 1'b0; det = '0;
    for (int j = 0; j < TMO - 1; j++) begin
      if (j < 8) begin rxv = 4'b0011; rx1 = 4'b0011; end
      else begin rxv = 4'b1100; rx1 = (j % 8 != 0) ? 4'b1100 : 4'b0000; end
      cyc();
    end
    chk("pt_active_hold", 2'd1, 4'hF, 1'b0, 1'b0);
    clr_in(); cyc(); chk("pt_config", 2'd2, 4'b0011, 1'b0, 1'b0);
    for (int j = 0; j < 16; j++) begin
      rxv = (j < 8) ? 4'b0111 : 4'h0; rx2 = (j < 8) ? 4'b0011 : 4'h0; rx1 = (j < 8) ? 4'b0100 : 4'h0;
      cyc();
    end
    chk("pt_cfg_hold", 2'd2, 4'b0011, 1'b0, 1'b0);
    clr_in(); cyc(); chk("pt_done", 2'd0, 4'b0011, 1'b1, 1'b0);

    // Consecutive-match reset on lane 2, then async reset mid-CONFIG, restart, hard timeout
    do_reset();
    det = 4'b0100; start = 1'b1; ready = 1'b1; cyc(); start = 1'b0; det = '0;
    for (int j = 0; j < 20; j++) begin
      rxv = (j <= 7 || j >= 12) ? 4'b0100 : 4'h0;
      rx1 = (j < 7 || j >= 12) ? 4'b0100 : 4'h0;
      cyc();
    end
    chk("cr_hold", 2'd1, 4'b0100, 1'b0, 1'b0);
    clr_in(); cyc(); chk("cr_config", 2'd2, 4'b0100, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      rxv = 4'b0100; rx2 = 4'b0100; cyc();
    end
    clr_in();
    #2 rst = 1'b1;
    #1 chk("rst_async", 2'd0, 4'h0, 1'b0, 1'b0);
    cyc(); rst = 1'b0; cyc();
    det = 4'b0100; start = 1'b1; cyc(); start = 1'b0; det = '0;
    chk("rs_enter", 2'd1, 4'b0100, 1'b0, 1'b0);
    for (int j = 0; j < TMO - 1; j++) begin
      rxv = (j < 3) ? 4'b0100 : 4'h0; rx1 = rxv; cyc();
    end
    chk("ht_hold", 2'd1, 4'b0100, 1'b0, 1'b0);
    clr_in(); cyc(); chk("ht_timeout", 2'd0, 4'h0, 1'b0, 1'b1);
    cyc(); chk("ht_clear", 2'd0, 4'h0, 1'b0, 1'b0);

    // 50% ready: only accepted sets advance the TS1 count
    do_reset();
    det = 4'hF; start = 1'b1; ready = 1'b1; cyc(); start = 1'b0; det = '0;
    for (int j = 0; j < 31; j++) begin
      ready = (j % 2 == 0); rxv = (j < 8) ? 4'hF : 4'h0; rx1 = rxv; cyc();
    end
    chk("rdy_hold", 2'd1, 4'hF, 1'b0, 1'b0);
    cyc(); chk("rdy_config", 2'd2, 4'hF, 1'b0, 1'b0);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 20000; c++) begin
      start = ($urandom_range(0, 39) == 0);
      det   = ($urandom_range(0, 7) == 0) ? '0 : NL'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      rxv   = NL'($urandom);
      for (int i = 0; i < NL; i++) begin
        rx2[i] = ($urandom_range(0, 15) != 0);
        rx1[i] = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 4999) == 0);
      cyc();
    end
    rst = 1'b0; clr_in(); cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ltssm_polling_ctrl.md
# ltssm_polling_ctrl

Sequences the LTSSM Polling substates: Polling.Active and then Polling.Configuration. It sits between the top-level LTSSM controller and the per-lane ordered-set transmit and receive logic. It is launched when the controller enters POLLING with the lane mask captured in Detect. It tells the transmitter which training set (TS1 or TS2) to send and on which lanes, counts sent and received training sets, and reports either success (advance to Configuration) or timeout (return to Detect).

## Interface
- NUM_LANES, 1, number of lanes.
- TS1_MIN_TX, 1024, TS1s that must be sent in Polling.Active before exit.
- RX_MATCH, 8, consecutive matching training sets required per lane.
- TS2_MIN_TX, 16, TS2s that must be sent after the first TS2 is received.
- TIMEOUT_CYCLES, 24000, per-substate timeout in clk_i cycles (24 ms equivalent; reduced in simulation).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  single-cycle pulse: enter Polling. Ignored unless state is IDLE.
- lanes_detected_i  in  NUM_LANES  lanes that detected a receiver. Sampled when start_i is accepted.
- tx_os_ready_i  in  1  the transmitter accepts the requested ordered set in this cycle.
- rx_os_valid_i  in  NUM_LANES  per-lane strobe: one ordered set received.
- rx_ts1_i  in  NUM_LANES  qualifies rx_os_valid_i: the set is a TS1 with PAD link/lane.
- rx_ts2_i  in  NUM_LANES  qualifies rx_os_valid_i: the set is a TS2 with PAD link/lane.
- tx_os_req_o  out  1  request to transmit one ordered set.
- tx_os_type_o  out  2  0 = none, 1 = TS1, 2 = TS2.
- tx_lanes_o  out  NUM_LANES  active lane mask.
- state_o  out  2  0 = IDLE, 1 = ACTIVE, 2 = CONFIG.
- done_o  out  1  single-cycle pulse: Polling complete, proceed to Configuration.
- timeout_o  out  1  single-cycle pulse: Polling failed, return to Detect.

## Operation
- **IDLE**
  - No transmit request; all counters are held at 0.
  - start_i with lanes_detected_i != 0: latch the mask into the active lanes and go to ACTIVE.
  - start_i with mask == 0: pulse timeout_o and stay in IDLE.
- **ACTIVE**
  - Request TS1 on the active lanes.
  - ts_tx_cnt increments on each cycle with tx_os_req_o && tx_os_ready_i. It saturates at max(TS1_MIN_TX, TS2_MIN_TX).
  - Per-lane rx_cnt:
    - rx_os_valid && (rx_ts1 || rx_ts2): increment, saturating at RX_MATCH.
    - rx_os_valid with neither qualifier: clear to 0.
  - Lane matched = rx_cnt == RX_MATCH.
  - Exit to CONFIG when ts_tx_cnt >= TS1_MIN_TX and every active lane is matched.
  - At tmr == TIMEOUT_CYCLES-1, with the exit condition false:
    - If ts_tx_cnt >= TS1_MIN_TX and at least one active lane is matched: go to CONFIG, and the active lanes become the matched lanes.
    - Otherwise: pulse timeout_o and go to IDLE.
- **CONFIG**
  - On entry, clear tmr, ts_tx_cnt, all rx_cnt and seen_ts2.
  - Request TS2.
  - Per-lane rx_cnt:
    - Increments on rx_os_valid && rx_ts2.
    - Clears on any other received set.
  - seen_ts2 sets on the first rx_ts2 on any active lane.
  - ts_tx_cnt counts only while seen_ts2 is set, including the cycle in which seen_ts2 is being set.
  - Exit when all active lanes are matched and ts_tx_cnt >= TS2_MIN_TX: pulse done_o and go to IDLE.
  - On timeout: pulse timeout_o and go to IDLE.
- **Counter and mask rules**
  - tmr counts cycles in ACTIVE/CONFIG; width is $clog2(TIMEOUT_CYCLES).
  - Counter widths are $clog2(max + 1).
  - Receive strobes on inactive lanes are ignored.
  - tx_lanes_o holds the active lanes in ACTIVE/CONFIG. After done_o it keeps the final mask until the next accepted start_i; it is cleared on timeout.

## Timing
- All outputs are registered.
- Reset value of every output: tx_os_req_o = 0, tx_os_type_o = 0, tx_lanes_o = 0, state_o = 0, done_o = 0, timeout_o = 0.
- Sequence latencies:
  - start_i accepted at cycle N: state_o = 1, tx_os_req_o = 1 and tx_os_type_o = 1 at N+1.
  - Exit condition true at cycle M: state_o changes at M+1; done_o or timeout_o is high for M+1 only.
  - tx_os_req_o drops in the same cycle state_o returns to IDLE.
- Transmit handshake:
  - tx_os_req_o stays high until a state change; there are no bubbles between accepts.
  - tx_os_type_o is stable while tx_os_req_o is high within a state.
- Simultaneous events:
  - Exit condition and timeout in the same cycle: the exit wins.
  - A receive clear and an increment on the same lane cannot coincide, because they are one strobe.
- rst_i asserted mid-operation: immediate return to IDLE with all outputs 0; no done_o or timeout_o pulse.

## Test plan
All scenarios use NUM_LANES = 4, TS1_MIN_TX = 16, RX_MATCH = 8, TS2_MIN_TX = 16, TIMEOUT_CYCLES = 1000.
- **Happy path**
  - Stimulus: lanes 4'b1111, tx_os_ready_i = 1, 8 TS1 on all lanes, then 8 TS2 on all lanes after CONFIG entry.
  - Response: ACTIVE exits after the 16th TS1 accepted; done_o pulses after the 16th TS2 following the first received TS2; tx_lanes_o = 4'b1111.
- **Consecutive reset**
  - Stimulus: lane 2 receives 7 TS1, then 1 non-TS set, then 8 TS1.
  - Response: no exit until the second run of 8 completes.
- **Partial-lane timeout**
  - Stimulus: only lanes 0 and 1 reach 8 TS1 by cycle 999.
  - Response: enter CONFIG with tx_lanes_o = 4'b0011; later done_o pulses with 4'b0011.
- **Hard timeout**
  - Stimulus: no received sets.
  - Response: timeout_o pulses 1000 cycles after entering ACTIVE; state_o = 0; tx_lanes_o = 0.
- **Edge starts**
  - start_i with lanes 0: immediate timeout_o pulse.
  - start_i while in ACTIVE: ignored.
  - tx_os_ready_i toggling at 50%: ts_tx_cnt counts only accepts.
- **Reset mid-CONFIG**
  - Stimulus: assert rst_i in CONFIG.
  - Response: all outputs 0 asynchronously; a subsequent start_i runs from a fresh count.
